// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OpMul   = 2'b00,
        OpMulhu = 2'b01,
        OpDivu  = 2'b10,
        OpRemu  = 2'b11
    } muldiv_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StNeg,
        StCalc,
        StDone
    } muldiv_state_e;

    localparam int unsigned MULDIV_ITER = 32;

    function automatic logic is_div(input muldiv_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/adder_32bit.sv
// 32-bit ripple-carry adder, no carry-in; c_o is the carry-out of bit 31.
module adder_32bit (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] re_o,
    output logic        c_o
);

    logic [32:0] carry;

    always_comb begin
        carry    = '0;
        re_o     = '0;
        for (int i = 0; i < 32; i++) begin
            re_o[i]      = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
        c_o = carry[32];
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU sharing one 32-bit adder.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise divides return 0.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] result_o,
    output logic        busy_o,
    input  logic        flush_i
);

    localparam logic [4:0] LastIter = 5'(MULDIV_ITER - 1);

    muldiv_state_e state_q, state_d;
    muldiv_op_e    op_q, op_d, op_in;
    logic [4:0]    cnt_q, cnt_d;
    // opd holds the multiplicand for MUL, the divisor for DIV.
    logic [31:0]   opd_q, opd_d;
    // hi/lo hold {hi, multiplier} for MUL, {rem, q} for DIV.
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   result_q, result_d;
    logic [31:0]   add_a, add_b, add_sum;
    logic          add_co;
`ifdef MULDIV_DIV_EN
    logic [31:0]   negd_q, negd_d;
    logic          ge;
`endif

    assign op_in = muldiv_op_e'(op_i);

    always_comb begin
        add_a = hi_q;
        add_b = opd_q;
`ifdef MULDIV_DIV_EN
        if (state_q == StNeg) begin
            add_a = ~opd_q;
            add_b = 32'd1;
        end else if (is_div(op_q)) begin
            add_a = {hi_q[30:0], lo_q[31]};
            add_b = negd_q;
        end
`endif
    end

    adder_32bit u_adder (
        .a_i  (add_a),
        .b_i  (add_b),
        .re_o (add_sum),
        .c_o  (add_co)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        opd_d    = opd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
`ifdef MULDIV_DIV_EN
        negd_d   = negd_q;
        ge       = hi_q[31] | add_co;
`endif
        if (flush_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        op_d  = op_in;
                        cnt_d = '0;
                        if (!is_div(op_in)) begin
                            opd_d   = a_i;
                            hi_d    = '0;
                            lo_d    = b_i;
                            state_d = StCalc;
                        end else begin
`ifdef MULDIV_DIV_EN
                            if (b_i == '0) begin
                                result_d = (op_in == OpDivu) ? '1 : a_i;
                                state_d  = StDone;
                            end else begin
                                opd_d   = b_i;
                                hi_d    = '0;
                                lo_d    = a_i;
                                state_d = StNeg;
                            end
`else
                            result_d = '0;
                            state_d  = StDone;
`endif
                        end
                    end
                end
`ifdef MULDIV_DIV_EN
                StNeg: begin
                    negd_d  = add_sum;
                    state_d = StCalc;
                end
`endif
                StCalc: begin
                    cnt_d = cnt_q + 5'd1;
`ifdef MULDIV_DIV_EN
                    if (is_div(op_q)) begin
                        hi_d = ge ? add_sum : {hi_q[30:0], lo_q[31]};
                        lo_d = {lo_q[30:0], ge};
                    end else
`endif
                    if (lo_q[0]) begin
                        hi_d = {add_co, add_sum[31:1]};
                        lo_d = {add_sum[0], lo_q[31:1]};
                    end else begin
                        hi_d = {1'b0, hi_q[31:1]};
                        lo_d = {hi_q[0], lo_q[31:1]};
                    end
                    if (cnt_q == LastIter) begin
                        // MULHU and REMU take the upper register, MUL and DIVU the lower.
                        result_d = op_q[0] ? hi_d : lo_d;
                        state_d  = StDone;
                    end
                end
                StDone: begin
                    if (resp_ready_i) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            op_q     <= OpMul;
            cnt_q    <= '0;
            opd_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
`ifdef MULDIV_DIV_EN
            negd_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            opd_q    <= opd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
`ifdef MULDIV_DIV_EN
            negd_q   <= negd_d;
`endif
        end
    end

    assign req_ready_o  = (state_q == StIdle);
    assign resp_valid_o = (state_q == StDone);
    assign busy_o       = (state_q != StIdle);
    assign result_o     = result_q;

endmodule
